mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single RAM port.
// Each grant captures one transaction, which ends in a hit, an error pulse, or a silent drop.
//
// state | meaning
// IDLE  | no transaction outstanding, evaluating requests
// DACC  | data transaction outstanding on RAM
// IACC  | instruction fetch outstanding on RAM
// DONE  | single recovery cycle before returning to IDLE
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [4:0] CNT_LAST  = 5'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic        r_last_d;
  logic [4:0]  r_cnt;
  logic [31:0] r_addr, r_store;
  logic        r_ren, r_wen;

  logic w_dreq, w_gnt_d, w_gnt_i, w_active, w_req;

  // A pending fetch wins over data right after a data hit, so neither side starves.
  assign w_dreq   = dREN | dWEN;
  assign w_gnt_d  = (r_state == IDLE) && w_dreq && !(r_last_d && iREN);
  assign w_gnt_i  = (r_state == IDLE) && iREN && !w_gnt_d;
  assign w_active = (r_state == DACC) || (r_state == IACC);
  assign w_req    = (r_state == DACC) ? w_dreq : iREN;

  always_comb begin
    w_next = r_state;
    dhit   = 1'b0;
    ihit   = 1'b0;
    err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_d)      w_next = DACC;
        else if (w_gnt_i) w_next = IACC;
      end
      DACC, IACC: begin
        if (ramstate == RS_ACCESS) begin
          dhit   = (r_state == DACC);
          ihit   = (r_state == IACC);
          w_next = DONE;
        end else if ((ramstate == RS_ERROR) || (r_cnt == CNT_LAST)) begin
          err    = 1'b1;
          w_next = DONE;
        end else if (!w_req) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign dload    = dhit ? ramload : 32'd0;
  assign iload    = ihit ? ramload : 32'd0;
  assign ramREN   = r_ren;
  assign ramWEN   = r_wen;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_cnt    <= 5'd0;
      r_addr   <= 32'd0;
      r_store  <= 32'd0;
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gnt_d || w_gnt_i) begin
        r_cnt   <= 5'd0;
        r_addr  <= w_gnt_d ? daddr : iaddr;
        r_store <= w_gnt_d ? dstore : 32'd0;
        r_wen   <= w_gnt_d && dWEN;
        r_ren   <= w_gnt_i || (w_gnt_d && !dWEN);
      end else if (w_active) begin
        r_cnt <= r_cnt + 5'd1;
        if (w_next == DONE) begin
          r_ren <= 1'b0;
          r_wen <= 1'b0;
        end
      end
      if (dhit)      r_last_d <= 1'b1;
      else if (ihit) r_last_d <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction bench for mem_arbiter with a queue-based scoreboard.
// The driver predicts each transaction's outcome from the arbitration rules; a monitor checks pulses.
module tb_mem_arbiter;
  localparam int TIMEOUT = 16;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
  localparam int SC_ACC = 0, SC_ERR = 1, SC_TMO = 2, SC_DROP = 3;

  logic        CLK = 1'b0, nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = RS_FREE;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, err;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_err;
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  bit          m_last_d = 1'b0;
  bit          exp_active = 1'b0, exp_ren = 1'b0, exp_wen = 1'b0;
  logic [31:0] exp_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: strobe expectations every cycle, scoreboard pop on any hit/err pulse.
  always @(negedge CLK) begin
    exp_t e;
    chk("ramREN", 32'(ramREN), 32'(exp_active && exp_ren));
    chk("ramWEN", 32'(ramWEN), 32'(exp_active && exp_wen));
    if (exp_active) chk("ramaddr", ramaddr, exp_addr);
    chk("hit_excl", 32'(ihit && dhit), 32'd0);
    if (!dhit) chk("dload_zero", dload, 32'd0);
    if (!ihit) chk("iload_zero", iload, 32'd0);
    if (ihit || dhit || err) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, ihit, dhit, err}, 32'd0);
      end else begin
        e = q.pop_front();
        if (e.is_err) begin
          chk("err", 32'(err), 32'd1);
          chk("err_nohit", {30'd0, ihit, dhit}, 32'd0);
        end else begin
          chk("err_on_hit", 32'(err), 32'd0);
          chk("dhit", 32'(dhit), 32'(e.is_d));
          chk("ihit", 32'(ihit), 32'(!e.is_d));
          chk("load", e.is_d ? dload : iload, e.load);
          chk("hit_addr", ramaddr, e.addr);
          chk("hit_wen", 32'(ramWEN), 32'(e.wr));
          if (e.wr) chk("ramstore", ramstore, e.store);
        end
      end
    end
  end

  // Drives one request set; returns one cycle into IDLE after DONE, just past a rising edge.
  task automatic run_txn(input bit ir, input bit dr, input bit dw, input int scen, input int k,
                         input bit drop_at_hit);
    exp_t       e;
    bit         gd, done;
    logic [1:0] rs;
    iaddr = $urandom; daddr = $urandom; dstore = $urandom;
    iREN = ir; dREN = dr; dWEN = dw; ramstate = RS_FREE;
    if (!(ir || dr || dw)) begin
      @(posedge CLK); #1;
      return;
    end
    gd      = (dr || dw) && !(m_last_d && ir);
    e.is_d  = gd;
    e.wr    = gd && dw;
    e.addr  = gd ? daddr : iaddr;
    e.store = dstore;
    e.is_err = 1'b0;
    e.load  = '0;
    @(posedge CLK); #1;
    exp_active = 1'b1; exp_ren = !e.wr; exp_wen = e.wr; exp_addr = e.addr;
    done = 1'b0;
    for (int n = 1; !done; n++) begin
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      rs = 2'($urandom_range(0, 1));
      if (scen == SC_ACC && n == k) rs = RS_ACCESS;
      if (scen == SC_ERR && n == k) rs = RS_ERROR;
      if ((scen == SC_DROP && n >= k) || (scen == SC_ACC && drop_at_hit && n == k)) begin
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      end
      ramstate = rs;
      if (rs == RS_ACCESS) begin
        e.load = ramload;
        q.push_back(e);
        m_last_d = gd;
        done = 1'b1;
      end else if (rs == RS_ERROR || n == TIMEOUT) begin
        e.is_err = 1'b1;
        q.push_back(e);
        done = 1'b1;
      end else if (!(gd ? (dREN || dWEN) : iREN)) begin
        done = 1'b1;
      end
      @(posedge CLK); #1;
    end
    exp_active = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
    @(posedge CLK); #1;
  endtask

  initial begin
    int scen, k;
    logic [31:0] a;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_pulses", {29'd0, ihit, dhit, err}, 32'd0);
    chk("rst_loads", iload | dload, 32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Fairness from reset, immediate write, timeout, error, drop then re-grant.
    run_txn(1, 1, 0, SC_ACC, 2, 0);
    run_txn(1, 1, 0, SC_ACC, 3, 0);
    run_txn(0, 1, 1, SC_ACC, 1, 0);
    run_txn(0, 0, 1, SC_ACC, 1, 1);
    run_txn(1, 0, 0, SC_TMO, 0, 0);
    run_txn(0, 1, 0, SC_ERR, 2, 0);
    run_txn(1, 0, 0, SC_DROP, 3, 0);
    run_txn(1, 0, 0, SC_TMO, 0, 0);
    run_txn(1, 0, 0, SC_ACC, TIMEOUT, 0);

    for (int i = 0; i < 120; i++) begin
      scen = $urandom_range(0, 3);
      case (scen)
        SC_ACC:  k = $urandom_range(1, TIMEOUT);
        SC_ERR:  k = $urandom_range(1, TIMEOUT);
        SC_DROP: k = $urandom_range(1, TIMEOUT - 1);
        default: k = 0;
      endcase
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), scen, k, 1'($urandom));
    end

    // Reset in the middle of a data write, then a lone fetch is granted.
    a = 32'h0000_0200;
    daddr = a; dstore = $urandom; dWEN = 1'b1; ramstate = RS_BUSY;
    @(posedge CLK); #1;
    exp_active = 1'b1; exp_ren = 1'b0; exp_wen = 1'b1; exp_addr = a;
    chk("pre_rst_wen", 32'(ramWEN), 32'd1);
    @(posedge CLK); #1;
    nRST = 1'b0; exp_active = 1'b0; m_last_d = 1'b0;
    #1;
    chk("midrst_wen", 32'(ramWEN), 32'd0);
    chk("midrst_pulses", {29'd0, ihit, dhit, err}, 32'd0);
    @(posedge CLK); #1;
    dWEN = 1'b0; nRST = 1'b1;
    run_txn(1, 0, 0, SC_ACC, 2, 0);
    run_txn(1, 1, 1, SC_ACC, 1, 0);

    repeat (3) @(posedge CLK);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
